// File: rtl/mc_cpu_ctrl.sv
// mc_cpu_ctrl: multi-cycle CPU control FSM with memory handshake, retire counter and error flags
module mc_cpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Run,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             PC_We,
  output logic             IR_We,
  output logic             Mem_Rd,
  output logic             Mem_Wr,
  output logic             IorD,
  output logic             Reg_We,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       State,
  output logic             Inst_Done,
  output logic [CNT_W-1:0] Inst_Cnt,
  output logic             Illegal,
  output logic             Bus_Err
);
  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3,
                         MEM_RD = 4'd4, MEM_WB = 4'd5, MEM_WR = 4'd6, EXEC_R = 4'd7,
                         WB_R = 4'd8, EXEC_I = 4'd9, WB_I = 4'd10, BRANCH = 4'd11, JUMP = 4'd12;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam int WW = $clog2(MEM_TIMEOUT);
  logic [3:0] state, nxt, done_nxt;
  logic [WW-1:0] wait_cnt;
  logic waiting, timeout, legal;
  assign State = state;
  assign waiting = state == FETCH || state == MEM_RD || state == MEM_WR;
  // the counter only ever reaches MEM_TIMEOUT-1; one more low cycle is the timeout
  assign timeout = waiting && !Mem_Ready && wait_cnt == WW'(MEM_TIMEOUT - 1);
  assign legal = Op == OP_R || Op == OP_LW || Op == OP_SW || Op == OP_BEQ || Op == OP_ADDI || Op == OP_J;
  assign done_nxt = Run ? FETCH : IDLE;
  // next-state selection; a timed-out wait falls back to IDLE
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = (Run && !Bus_Err) ? FETCH : IDLE;
      FETCH:    nxt = timeout ? IDLE : Mem_Ready ? DECODE : FETCH;
      DECODE:   nxt = Op == OP_R ? EXEC_R : (Op == OP_LW || Op == OP_SW) ? MEM_ADDR :
                      Op == OP_BEQ ? BRANCH : Op == OP_ADDI ? EXEC_I : Op == OP_J ? JUMP : IDLE;
      MEM_ADDR: nxt = Op == OP_SW ? MEM_WR : MEM_RD;
      MEM_RD:   nxt = timeout ? IDLE : Mem_Ready ? MEM_WB : MEM_RD;
      MEM_WR:   nxt = timeout ? IDLE : Mem_Ready ? done_nxt : MEM_WR;
      EXEC_R:   nxt = WB_R;
      EXEC_I:   nxt = WB_I;
      MEM_WB, WB_R, WB_I, BRANCH, JUMP: nxt = done_nxt;
      default:  nxt = IDLE;
    endcase
  end
  // datapath controls decoded from the current state
  always_comb begin
    {PC_We, IR_We, Mem_Rd, Mem_Wr, IorD, Reg_We, RegDst, MemToReg, ALUSrcA} = '0;
    {ALUSrcB, ALUOp, PCSrc} = '0;
    {Inst_Done, Illegal} = '0;
    case (state)
      FETCH: begin
        Mem_Rd = 1'b1;
        ALUSrcB = 2'b01;
        IR_We = Mem_Ready;
        PC_We = Mem_Ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !legal;
      end
      MEM_ADDR, EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: {Mem_Rd, IorD} = 2'b11;
      MEM_WB: {Reg_We, MemToReg, Inst_Done} = 3'b111;
      MEM_WR: begin
        {Mem_Wr, IorD} = 2'b11;
        Inst_Done = Mem_Ready;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
      end
      WB_R: {Reg_We, RegDst, Inst_Done} = 3'b111;
      WB_I: {Reg_We, Inst_Done} = 2'b11;
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCSrc = 2'b01;
        PC_We = Zero;
        Inst_Done = 1'b1;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PC_We = 1'b1;
        Inst_Done = 1'b1;
      end
      default: ;
    endcase
  end
  // state, wait counter, retire counter and sticky bus error
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      Inst_Cnt <= '0;
      Bus_Err <= 1'b0;
    end else begin
      state <= nxt;
      wait_cnt <= (waiting && !Mem_Ready && !timeout) ? wait_cnt + WW'(1) : '0;
      if (Inst_Done) Inst_Cnt <= Inst_Cnt + CNT_W'(1);
      if (timeout) Bus_Err <= 1'b1;
    end
endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb_mc_cpu_ctrl: directed self-checking bench for mc_cpu_ctrl
module tb_mc_cpu_ctrl;
  logic Clk = 1'b0, Rst_n, Run, Zero, Mem_Ready;
  logic [5:0] Op;
  logic PC_We, IR_We, Mem_Rd, Mem_Wr, IorD, Reg_We, RegDst, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State, Inst_Cnt;
  logic Inst_Done, Illegal, Bus_Err;
  logic [14:0] ctrl;
  int total = 0, bad = 0;
  localparam logic [14:0] C_F1  = 15'b1_1_1_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] C_F0  = 15'b0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] C_DEC = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] C_MA  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] C_MRD = 15'b0_0_1_0_1_0_0_0_0_00_00_00;
  localparam logic [14:0] C_MWB = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] C_MWR = 15'b0_0_0_1_1_0_0_0_0_00_00_00;
  localparam logic [14:0] C_EXR = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] C_WBR = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [14:0] C_WBI = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [14:0] C_BZ1 = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] C_BZ0 = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] C_J   = 15'b1_0_0_0_0_0_0_0_0_00_00_10;

  assign ctrl = {PC_We, IR_We, Mem_Rd, Mem_Wr, IorD, Reg_We, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  mc_cpu_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Op(Op), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_We(PC_We), .IR_We(IR_We), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .IorD(IorD),
    .Reg_We(Reg_We), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .State(State), .Inst_Done(Inst_Done),
    .Inst_Cnt(Inst_Cnt), .Illegal(Illegal), .Bus_Err(Bus_Err)
  );

  always #10 Clk = ~Clk;

  task automatic cyc;
    @(posedge Clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 0; Run = 0; Op = 6'b000000; Zero = 0; Mem_Ready = 1;
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_state", State, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_cnt", Inst_Cnt, 0);
    chk("rst_err", Bus_Err, 0);
    Rst_n = 1; Run = 1;
    cyc; chk("r_fetch", State, 1); chk("r_fetch_ctl", ctrl, C_F1); chk("r_fetch_done", Inst_Done, 0);
    cyc; chk("r_dec", State, 2); chk("r_dec_ctl", ctrl, C_DEC);
    cyc; chk("r_exec", State, 7); chk("r_exec_ctl", ctrl, C_EXR); chk("r_exec_done", Inst_Done, 0);
    cyc; chk("r_wb", State, 8); chk("r_wb_ctl", ctrl, C_WBR); chk("r_wb_done", Inst_Done, 1); chk("r_wb_cnt", Inst_Cnt, 0);
    cyc; chk("r_next", State, 1); chk("r_cnt", Inst_Cnt, 1); chk("r_next_done", Inst_Done, 0);
    Op = 6'b100011;
    cyc; chk("lw_dec", State, 2);
    cyc; chk("lw_addr", State, 3); chk("lw_addr_ctl", ctrl, C_MA);
    Mem_Ready = 0;
    cyc; #1; chk("lw_rd0", State, 4); chk("lw_rd0_ctl", ctrl, C_MRD);
    cyc; chk("lw_rd1", State, 4); chk("lw_rd1_ctl", ctrl, C_MRD);
    cyc; Mem_Ready = 1; #1; chk("lw_rd2", State, 4); chk("lw_rd2_ctl", ctrl, C_MRD);
    cyc; chk("lw_wb", State, 5); chk("lw_wb_ctl", ctrl, C_MWB); chk("lw_wb_done", Inst_Done, 1);
    cyc; chk("lw_next", State, 1); chk("lw_cnt", Inst_Cnt, 2);
    Op = 6'b000100; Zero = 1;
    cyc; chk("beq1_dec", State, 2);
    cyc; #1; chk("beq1_br", State, 11); chk("beq1_ctl", ctrl, C_BZ1); chk("beq1_done", Inst_Done, 1);
    cyc; chk("beq1_next", State, 1);
    Zero = 0;
    cyc; chk("beq0_dec", State, 2);
    cyc; #1; chk("beq0_br", State, 11); chk("beq0_ctl", ctrl, C_BZ0); chk("beq0_done", Inst_Done, 1);
    cyc; chk("beq0_next", State, 1); chk("beq_cnt", Inst_Cnt, 4);
    Op = 6'b111111;
    cyc; chk("ill_dec", State, 2); chk("ill_pulse", Illegal, 1); chk("ill_done", Inst_Done, 0); chk("ill_ctl", ctrl, C_DEC);
    cyc; chk("ill_idle", State, 0); chk("ill_low", Illegal, 0); chk("ill_cnt", Inst_Cnt, 4);
    cyc; chk("ill_restart", State, 1);
    Op = 6'b101011;
    cyc; chk("sw_dec", State, 2);
    cyc; chk("sw_addr", State, 3);
    cyc; Mem_Ready = 0; #1; chk("sw_wr0", State, 6); chk("sw_wr0_ctl", ctrl, C_MWR); chk("sw_wr0_done", Inst_Done, 0);
    cyc; Mem_Ready = 1; #1; chk("sw_wr1", State, 6); chk("sw_wr1_done", Inst_Done, 1);
    cyc; chk("sw_next", State, 1); chk("sw_cnt", Inst_Cnt, 5);
    Op = 6'b001000;
    cyc; chk("addi_dec", State, 2);
    cyc; chk("addi_exec", State, 9); chk("addi_exec_ctl", ctrl, C_MA);
    cyc; chk("addi_wb", State, 10); chk("addi_wb_ctl", ctrl, C_WBI); chk("addi_wb_done", Inst_Done, 1);
    cyc; chk("addi_next", State, 1); chk("addi_cnt", Inst_Cnt, 6);
    Mem_Ready = 0; #1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_fetch%0d", i), State, 1);
      chk($sformatf("to_ctl%0d", i), ctrl, C_F0);
      chk($sformatf("to_err%0d", i), Bus_Err, 0);
      cyc;
    end
    chk("to_idle", State, 0); chk("to_err", Bus_Err, 1); chk("to_ctl", ctrl, 0);
    Mem_Ready = 1;
    repeat (3) cyc;
    chk("to_hold", State, 0); chk("to_hold_err", Bus_Err, 1); chk("to_hold_cnt", Inst_Cnt, 6);
    Rst_n = 0; #1;
    chk("rst2_state", State, 0); chk("rst2_err", Bus_Err, 0); chk("rst2_cnt", Inst_Cnt, 0);
    cyc; Rst_n = 1;
    cyc; Mem_Ready = 0; #1; chk("bd_fetch", State, 1);
    for (int i = 0; i < 13; i++) cyc;
    chk("bd_wait", State, 1); chk("bd_wait_err", Bus_Err, 0);
    cyc; Mem_Ready = 1; Op = 6'b000010; #1;
    chk("bd_last", State, 1); chk("bd_last_ctl", ctrl, C_F1);
    cyc; chk("bd_dec", State, 2); chk("bd_err", Bus_Err, 0);
    cyc; chk("j_jump", State, 12); chk("j_ctl", ctrl, C_J); chk("j_done", Inst_Done, 1);
    cyc; chk("j_next", State, 1); chk("j_cnt", Inst_Cnt, 1);
    for (int k = 0; k < 14; k++) begin
      cyc;
      cyc; chk($sformatf("jl_state%0d", k), State, 12);
      cyc;
    end
    chk("jl_cnt", Inst_Cnt, 15);
    cyc;
    cyc; Run = 0; #1;
    chk("jw_state", State, 12); chk("jw_ctl", ctrl, C_J); chk("jw_cnt", Inst_Cnt, 15);
    cyc; chk("jw_idle", State, 0); chk("jw_wrap", Inst_Cnt, 0); chk("jw_ctl_idle", ctrl, 0);
    cyc; chk("jw_stay", State, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_cpu_ctrl.md
Name: mc_cpu_ctrl

Overview:
- Multi-cycle control FSM that sequences the CPU datapath (PC, IR, register file, ALU, single shared instruction/data memory) through its execution steps.
- Supported instructions: R-type, lw, sw, beq, addi, j.
- Decodes opcode, drives all datapath enables and muxes, and handshakes with the memory via Mem_Ready.
- Provides a retired-instruction counter and error flags for the CPU top and its bench.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles of waiting on Mem_Ready before a bus error (≥2).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Run  in  1  enables fetching of new instructions.
- Op  in  6  IR[31:26].
- Zero  in  1  ALU zero flag.
- Mem_Ready  in  1  memory completes current read/write this cycle.
- PC_We  out  1  PC write enable.
- IR_We  out  1  IR write enable.
- Mem_Rd  out  1  memory read request.
- Mem_Wr  out  1  memory write request.
- IorD  out  1  address mux: 0=PC, 1=ALUOut.
- Reg_We  out  1  register file write enable.
- RegDst  out  1  write register: 0=rt, 1=rd.
- MemToReg  out  1  write data: 0=ALUOut, 1=MDR.
- ALUSrcA  out  1  0=PC, 1=rs.
- ALUSrcB  out  2  00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=use funct.
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- State  out  4  current state encoding, for debug.
- Inst_Done  out  1  one-cycle pulse when an instruction retires.
- Inst_Cnt  out  CNT_W  retired-instruction count.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.
- Bus_Err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE, Inst_Cnt=0, Bus_Err=0, wait counter=0.
  - All control outputs 0.
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, WB_R 8, EXEC_I 9, WB_I 10, BRANCH 11, JUMP 12. Unused codes go to IDLE.
- Outputs are combinational from State (plus Mem_Ready/Zero where stated). Any control not listed for a state is 0.
- IDLE:
  - All controls 0.
  - Goes to FETCH when Run=1 and Bus_Err=0.
- FETCH:
  - Mem_Rd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IR_We=PC_We=Mem_Ready.
  - Mem_Ready=1 moves to DECODE; otherwise hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Op: 000000→EXEC_R; 100011/101011→MEM_ADDR; 000100→BRANCH; 001000→EXEC_I; 000010→JUMP.
  - Any other Op: Illegal=1 this cycle, next IDLE.
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - lw→MEM_RD, sw→MEM_WR.
- MEM_RD:
  - Mem_Rd=1, IorD=1.
  - Mem_Ready moves to MEM_WB.
- MEM_WB:
  - Reg_We=1, RegDst=0, MemToReg=1, Inst_Done=1.
- MEM_WR:
  - Mem_Wr=1, IorD=1.
  - Inst_Done=Mem_Ready.
  - Mem_Ready ends the instruction.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next WB_R.
- WB_R: Reg_We=1, RegDst=1, MemToReg=0, Inst_Done=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next WB_I.
- WB_I: Reg_We=1, RegDst=0, MemToReg=0, Inst_Done=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PC_We=Zero, Inst_Done=1.
- JUMP: PCSrc=10, PC_We=1, Inst_Done=1.
- End of instruction: next state is FETCH if Run=1, else IDLE. Run deassertion never aborts an instruction in flight.
- Latency without wait states:
  - R/addi/beq/j: 4/4/3/3 cycles.
  - lw: 5 cycles; sw: 4 cycles.
  - Each Mem_Ready-low cycle adds one cycle.
- Inst_Cnt increments on every Inst_Done cycle and wraps from 2^CNT_W−1 to 0.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to any wait state, and in every cycle Mem_Ready=1.
  - Increments each cycle Mem_Ready=0.
  - On the MEM_TIMEOUT-th consecutive low cycle: Bus_Err←1, next state IDLE, no write enables issued.
  - Mem_Ready=1 in that same cycle completes normally; no error.
- Bus_Err stays 1 until reset; IDLE is held while it is set.
- Mid-operation reset returns immediately to IDLE with all controls 0. No partial writes are emitted after Rst_n falls.

Test Plan:
- Reset, then Run=1, Mem_Ready=1, Op=000000:
  - State sequence 1,2,7,8,1.
  - Inst_Done high in WB_R only; Inst_Cnt=1; Reg_We=RegDst=1 in WB_R.
- lw (100011), Mem_Ready low 2 cycles in MEM_RD:
  - Sequence 1,2,3,4,4,4,5.
  - Mem_Rd=IorD=1 throughout MEM_RD; MemToReg=1 and Reg_We=1 in MEM_WB.
- beq (000100) with Zero=1, then with Zero=0:
  - PC_We=1 with PCSrc=01 in the first case; PC_We=0 in the second.
  - Both retire in 3 cycles; Inst_Cnt +2.
- Op=111111:
  - Illegal pulses 1 cycle in DECODE; next IDLE; Inst_Cnt unchanged.
  - Run=1 restarts at FETCH.
- MEM_TIMEOUT=15, Mem_Ready held 0 in FETCH:
  - Bus_Err=1 after 15 cycles, State=0, IR_We never high.
  - Stays IDLE with Run=1 until Rst_n pulse.
- CNT_W=4, 16 j instructions (000010):
  - Inst_Cnt wraps 15→0.
  - Run dropped during JUMP → IDLE after JUMP completes, with PC_We=1 still issued.
